l1_cache: RTL and testbench
===========================

# l1_cache

Direct-mapped, write-back, write-allocate L1 cache that answers the pipeline's word-wide memory requests and fills or evicts 256-bit lines over the physical-memory port. One instance serves the instruction port and read/write/resp/rdata of the pipeline. A second instance serves the data port, including wdata/mbe. Hits respond in the request cycle, so the pipeline does not stall. Misses hold `mem_resp` low until the line is resident.

## Interface
Parameters:
- `S_INDEX`, 3 — index bits; `2**S_INDEX` sets.
- `S_OFFSET`, 5 — byte-offset bits; line = 256 bits. Fixed; other values unsupported.

Ports:
- `clk` in 1 — single clock, all state updates on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `mem_address` in 32 — CPU byte address; `[1:0]` ignored.
- `mem_read` in 1 — read request.
- `mem_write` in 1 — write request.
- `mem_wdata` in 32 — store data, already lane-shifted by CPU.
- `mem_mbe` in 4 — byte enables for write.
- `mem_resp` out 1 — request complete this cycle.
- `mem_rdata` out 32 — word `[4:2]` of indexed line.
- `pmem_address` out 32 — line address, `[4:0]`=0.
- `pmem_read` out 1 — line fetch request.
- `pmem_write` out 1 — line eviction request.
- `pmem_wdata` out 256 — evicted line.
- `pmem_rdata` in 256 — fetched line.
- `pmem_resp` in 1 — pmem transfer done, 1-cycle pulse.

## Operation
- Address split: tag = `[31:S_INDEX+5]`, index = `[S_INDEX+4:5]`, word = `[4:2]`.
- Per set: valid, dirty, tag, and 256-bit data, held in flip-flops so reads are combinational.
- Hit = `(mem_read|mem_write) & valid[idx] & tag[idx]==tag`, and only in state `CHECK`.
- Read hit:
  - `mem_resp`=1 in the same cycle.
  - `mem_rdata` = `data[idx][32*word +: 32]`.
- Write hit:
  - `mem_resp`=1 in the same cycle.
  - At the edge, bytes with `mem_mbe[i]`=1 take `mem_wdata[8i+:8]`, and `dirty[idx]`←1.
  - `mbe`=0 is a legal no-op write, but it still sets dirty.
- `mem_read` and `mem_write` both high: handled as a write.
- FSM states:
  - `CHECK` (reset state):
    - Idle or hit: stay in `CHECK`.
    - Miss with valid and dirty: go to `WB`.
    - Miss otherwise: go to `FETCH`.
  - `WB`:
    - Drive `pmem_write`=1, `pmem_address`={stored tag, idx, 5'b0}, and `pmem_wdata`=line.
    - On `pmem_resp`: dirty←0, go to `FETCH`.
  - `FETCH`:
    - Drive `pmem_read`=1, `pmem_address`={`mem_address[31:5]`, 5'b0}.
    - On `pmem_resp`: data←`pmem_rdata`, tag←request tag, valid←1, dirty←0, go to `CHECK`.
    - The access then hits in `CHECK`.
- CPU protocol: the request is held stable until `mem_resp`.
  - If the request drops mid-miss, the started WB/FETCH still completes and the line is installed.
- `mem_resp` is never asserted outside `CHECK`.
- `pmem_read` and `pmem_write` are never asserted together.

## Timing
- Reset (edge with `rst`=1):
  - State →`CHECK`; all valid and dirty bits cleared.
  - Next cycle: `mem_resp`=0, `pmem_read`=0, `pmem_write`=0.
  - `mem_rdata`, `pmem_address`, and `pmem_wdata` are don't-care but X-free.
  - Data and tag arrays are not cleared.
- Reset mid-miss: abort to `CHECK`; pmem strobes deassert the cycle after the reset edge.
- Hit latency: 0 cycles (combinational response).
- Clean miss: 1 cycle `CHECK`, then `FETCH` for N cycles until `pmem_resp`, then 1 hit cycle. Total N+2.
- Dirty miss: 1 + `WB` cycles + `FETCH` cycles + 1.
- pmem strobes are held high and stable until `pmem_resp`. They deassert the cycle after `pmem_resp` unless the next state drives the other strobe.
- Back-to-back hits to different sets: one `mem_resp` per cycle.
- Write hit followed by read of the same word next cycle returns the new data.

## Structure
- Package `cache_types`:
  - `cache_state_t` enum {`CHECK`, `WB`, `FETCH`}.
  - Localparams for tag, index, and offset widths, derived from `S_INDEX` and `S_OFFSET`.
- Sub-module `cache_control`:
  - FSM only. Inputs: hit, dirty, valid, request, `pmem_resp`.
  - Outputs: state, pmem strobes, and load enables (`ld_line`, `ld_tag`, `set_valid`, `set_dirty`, `clr_dirty`, `addr_sel`).
- Arrays, byte-enable merge, and muxes stay in `l1_cache`.

## Test plan
- Reset, then `mem_read` @0x0000_0040:
  - Miss goes to `FETCH` with `pmem_address`=0x40.
  - Drive `pmem_rdata` with word2=0xDEADBEEF and `pmem_resp` after 3 cycles.
  - Expect `mem_resp` next cycle, `mem_rdata`=0xDEADBEEF on read of 0x48.
- Write hit @0x48, `mbe`=4'b0010, `wdata`=0x0000AB00:
  - `mem_resp` same cycle.
  - Subsequent read returns 0xDEADABEF; dirty set.
- Read 0x0000_0140 (`S_INDEX`=3, same set, other tag):
  - First `pmem_write` of the line at 0x40 containing 0xDEADABEF.
  - Then `pmem_read` at 0x140.
  - Strobes never overlap.
- Hold request, assert `rst` during `FETCH`:
  - `pmem_read`=0 the cycle after.
  - Valid cleared; a re-read of 0x48 misses again.
- 8 consecutive reads to different sets after warm-up: 8 `mem_resp` in 8 cycles, zero pmem activity.

Source files
------------

// File: rtl/cache_types.sv
// Shared types and geometry for the direct-mapped L1 cache.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: controller state encoding, default geometry and the address
// field width helpers used by l1_cache and cache_control.
package cache_types;

  typedef enum logic [1:0] {
    CHECK = 2'd0,
    WB    = 2'd1,
    FETCH = 2'd2
  } cache_state_t;

  localparam int ADDR_W       = 32;
  localparam int WORD_W       = 32;
  localparam int S_INDEX_DEF  = 3;
  localparam int S_OFFSET_DEF = 5;
  // Line width follows the byte-offset width; only the 256-bit line is built.
  localparam int LINE_W       = 8 << S_OFFSET_DEF;
  localparam int TAG_W_DEF    = ADDR_W - S_INDEX_DEF - S_OFFSET_DEF;

  function automatic int tag_width(input int s_index, input int s_offset);
    return ADDR_W - s_index - s_offset;
  endfunction

  function automatic int word_sel_width(input int s_offset);
    return s_offset - 2;
  endfunction

endpackage

// File: rtl/cache_control.sv
// Miss-handling FSM for l1_cache: CHECK -> (WB) -> FETCH -> CHECK.
// Latency: hits resolve in CHECK with no extra cycle; misses add one CHECK
// cycle plus the WB/FETCH cycles. Backpressure: pmem strobes stay high until pmem_resp.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   hit, req_write, req         lookup result and request type for the indexed set
//   valid, dirty                state bits of the indexed set
//   pmem_resp                   pmem transfer done pulse
//   state                       current controller state
//   pmem_read, pmem_write       line fetch / eviction strobes (mutually exclusive)
//   ld_line, ld_tag             data / tag array write enables for the indexed set
//   set_valid, set_dirty, clr_dirty  state bit updates for the indexed set
//   addr_sel                    1: pmem address from stored tag (eviction)
module cache_control
  import cache_types::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         hit,
  input  logic         req_write,
  input  logic         req,
  input  logic         valid,
  input  logic         dirty,
  input  logic         pmem_resp,
  output cache_state_t state,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic         ld_line,
  output logic         ld_tag,
  output logic         set_valid,
  output logic         set_dirty,
  output logic         clr_dirty,
  output logic         addr_sel
);

  cache_state_t state_q;
  cache_state_t state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CHECK;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  always_comb begin
    state_d    = state_q;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    ld_line    = 1'b0;
    ld_tag     = 1'b0;
    set_valid  = 1'b0;
    set_dirty  = 1'b0;
    clr_dirty  = 1'b0;
    addr_sel   = 1'b0;
    case (state_q)
      CHECK: begin
        if (hit) begin
          // Store hit merges the write into the resident line.
          if (req_write) begin
            ld_line   = 1'b1;
            set_dirty = 1'b1;
          end
        end else if (req) begin
          state_d = (valid && dirty) ? WB : FETCH;
        end
      end
      WB: begin
        pmem_write = 1'b1;
        addr_sel   = 1'b1;
        if (pmem_resp) begin
          clr_dirty = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        // Runs to completion even if the CPU has dropped its request.
        pmem_read = 1'b1;
        if (pmem_resp) begin
          ld_line   = 1'b1;
          ld_tag    = 1'b1;
          set_valid = 1'b1;
          clr_dirty = 1'b1;
          state_d   = CHECK;
        end
      end
      default: begin
        state_d = CHECK;
      end
    endcase
  end

endmodule

// File: rtl/l1_cache.sv
// Direct-mapped write-back write-allocate L1 cache, 256-bit lines held in flops.
// Latency: hits respond combinationally in the request cycle; clean miss N+2,
// dirty miss 1+WB+FETCH+1 cycles. Backpressure: mem_resp held low until the line is resident.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   mem_address/read/write/wdata/mbe CPU word request (address[1:0] ignored)
//   mem_resp, mem_rdata               completion strobe and read word
//   pmem_address/read/write/wdata     line-granular physical memory request
//   pmem_rdata, pmem_resp             fetched line and transfer-done pulse
module l1_cache
  import cache_types::*;
#(
  parameter int S_INDEX  = S_INDEX_DEF,
  parameter int S_OFFSET = S_OFFSET_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   mem_address,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [WORD_W-1:0]   mem_wdata,
  input  logic [3:0]          mem_mbe,
  output logic                mem_resp,
  output logic [WORD_W-1:0]   mem_rdata,
  output logic [ADDR_W-1:0]   pmem_address,
  output logic                pmem_read,
  output logic                pmem_write,
  output logic [LINE_W-1:0]   pmem_wdata,
  input  logic [LINE_W-1:0]   pmem_rdata,
  input  logic                pmem_resp
);

  localparam int NUM_SETS = 1 << S_INDEX;
  localparam int TAG_W    = tag_width(S_INDEX, S_OFFSET);
  localparam int WSEL_W   = word_sel_width(S_OFFSET);

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [S_INDEX-1:0] idx;
    logic [WSEL_W-1:0]  word;
    logic [1:0]         byte_off;
  } cpu_addr_t;

  cpu_addr_t req_addr;
  assign req_addr = cpu_addr_t'(mem_address);

  logic unused_byte_off;
  assign unused_byte_off = ^req_addr.byte_off;

  // Per-set storage; only valid/dirty are reset.
  logic [LINE_W-1:0]   data_arr [NUM_SETS];
  logic [TAG_W-1:0]    tag_arr  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;

  cache_state_t state;
  logic req, hit;
  logic ld_line, ld_tag, set_valid, set_dirty, clr_dirty, addr_sel;
  logic set_valid_bit, set_dirty_bit;

  logic [LINE_W-1:0] cur_line;
  logic [LINE_W-1:0] merged_line;
  logic [LINE_W-1:0] line_d;
  logic [TAG_W-1:0]  cur_tag;

  assign set_valid_bit = valid_q[req_addr.idx];
  assign set_dirty_bit = dirty_q[req_addr.idx];

  // Tag/data are unreset; mask them with valid so outputs stay X-free after reset.
  assign cur_line = set_valid_bit ? data_arr[req_addr.idx] : '0;
  assign cur_tag  = set_valid_bit ? tag_arr[req_addr.idx]  : '0;

  assign req = mem_read | mem_write;
  assign hit = req && (state == CHECK) && set_valid_bit && (cur_tag == req_addr.tag);

  assign mem_resp  = hit;
  assign mem_rdata = cur_line[32*int'(req_addr.word) +: 32];

  // Byte-enable merge of the store word into the resident line.
  always_comb begin
    merged_line = cur_line;
    for (int b = 0; b < 4; b++) begin
      if (mem_mbe[b]) begin
        merged_line[32*int'(req_addr.word) + 8*b +: 8] = mem_wdata[8*b +: 8];
      end
    end
  end

  assign line_d = (state == FETCH) ? pmem_rdata : merged_line;

  assign pmem_address = addr_sel ? {cur_tag, req_addr.idx, {S_OFFSET{1'b0}}}
                                 : {req_addr.tag, req_addr.idx, {S_OFFSET{1'b0}}};
  assign pmem_wdata   = cur_line;

  cache_control u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .hit        (hit),
    .req_write  (mem_write),
    .req        (req),
    .valid      (set_valid_bit),
    .dirty      (set_dirty_bit),
    .pmem_resp  (pmem_resp),
    .state      (state),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .ld_line    (ld_line),
    .ld_tag     (ld_tag),
    .set_valid  (set_valid),
    .set_dirty  (set_dirty),
    .clr_dirty  (clr_dirty),
    .addr_sel   (addr_sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (set_valid) begin
        valid_q[req_addr.idx] <= 1'b1;
      end
      if (set_dirty) begin
        dirty_q[req_addr.idx] <= 1'b1;
      end else if (clr_dirty) begin
        dirty_q[req_addr.idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld_line) begin
      data_arr[req_addr.idx] <= line_d;
    end
    if (ld_tag) begin
      tag_arr[req_addr.idx] <= req_addr.tag;
    end
  end

endmodule

// File: tb/tb_l1_cache.sv
// Self-checking bench for l1_cache: directed scenarios plus random traffic
// against a line-granular residency model and an architectural word memory.
// The bench plays the physical memory with fixed or random response latency.
module tb_l1_cache;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_mbe;
  logic         mem_resp;
  logic [31:0]  mem_rdata;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  always #5 clk = ~clk;

  l1_cache #(.S_INDEX(3), .S_OFFSET(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_wdata    (mem_wdata),
    .mem_mbe      (mem_mbe),
    .mem_resp     (mem_resp),
    .mem_rdata    (mem_rdata),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference world: backing store by line number, architectural overrides by word number.
  logic [255:0] bk   [int unsigned];
  logic [31:0]  arch [int unsigned];
  // Residency model: which line each set holds and whether it is modified.
  int unsigned  res_line  [8];
  bit           res_vld   [8];
  bit           res_dirty [8];

  // Physical memory responder state.
  int           fixed_lat = -1;
  bit           pm_busy = 0;
  bit           pm_rd;
  logic [31:0]  pm_addr;
  int           pm_left;
  int           acc_pm_cycles;
  logic [31:0]  ops_addr [$];
  bit           ops_rd   [$];
  logic [255:0] last_wb_data;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  function automatic logic [255:0] bk_line(input int unsigned ln);
    logic [255:0] l;
    if (bk.exists(ln)) return bk[ln];
    for (int w = 0; w < 8; w++) l[32*w +: 32] = init_word((ln << 5) + 32'(4 * w));
    return l;
  endfunction

  function automatic logic [31:0] arch_word(input int unsigned wa);
    logic [255:0] l;
    if (arch.exists(wa)) return arch[wa];
    l = bk_line(wa >> 3);
    return l[32*(wa % 8) +: 32];
  endfunction

  function automatic logic [255:0] arch_line(input int unsigned ln);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = arch_word(ln * 8 + w);
    return l;
  endfunction

  function automatic logic [31:0] op_addr(input int i);
    if (ops_addr.size() > i) return ops_addr[i];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic bit op_is_rd(input int i);
    if (ops_rd.size() > i) return ops_rd[i];
    return 1'b0;
  endfunction

  // Called at the input-drive point of each cycle (just after the rising edge).
  task automatic serve_pmem();
    pmem_resp = 1'b0;
    if (pmem_read || pmem_write) begin
      if (!pm_busy) begin
        pm_busy = 1'b1;
        pm_rd   = pmem_read;
        pm_addr = pmem_address;
        pm_left = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        ops_addr.push_back(pmem_address);
        ops_rd.push_back(pmem_read);
        if (pmem_write) begin
          last_wb_data = pmem_wdata;
          check("wb_data", pmem_wdata, arch_line(pmem_address >> 5));
        end
      end else begin
        check("strobe_stable", 256'({pmem_read, pmem_write, pmem_address}),
              256'({pm_rd, !pm_rd, pm_addr}));
      end
      acc_pm_cycles++;
      if (pm_left == 0) begin
        pmem_resp = 1'b1;
        pm_busy   = 1'b0;
        if (pm_rd) pmem_rdata = bk_line(pm_addr >> 5);
        else       bk[pm_addr >> 5] = pmem_wdata;
      end else begin
        pm_left--;
      end
    end else if (pm_busy) begin
      check("strobe_held", 256'(0), 256'(1));
      pm_busy = 1'b0;
    end
  endtask

  task automatic idle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    serve_pmem();
    @(negedge clk);
    check("idle_resp", 256'(mem_resp), 256'(0));
    check("idle_pmem", 256'(pmem_read | pmem_write), 256'(0));
    @(posedge clk); #1;
  endtask

  task automatic access(input logic [31:0] addr, input bit we, input logic [31:0] wd,
                        input logic [3:0] be, input bit rd_too,
                        output logic [31:0] rd, output int cyc, output bit was_hit);
    int          set;
    int unsigned ln;
    int unsigned victim;
    bit          exp_hit, exp_wb, done;
    int          exp_ops;
    logic [31:0] w;
    set     = int'(addr[7:5]);
    ln      = addr >> 5;
    victim  = res_line[set];
    exp_hit = res_vld[set] && (res_line[set] == ln);
    exp_wb  = !exp_hit && res_vld[set] && res_dirty[set];
    done    = 1'b0;
    cyc     = 0;
    rd      = '0;
    acc_pm_cycles = 0;
    ops_addr.delete();
    ops_rd.delete();
    mem_address = addr;
    mem_read    = !we || rd_too;
    mem_write   = we;
    mem_wdata   = wd;
    mem_mbe     = be;
    while (!done && cyc < 100) begin
      serve_pmem();
      @(negedge clk);
      cyc++;
      check("no_overlap", 256'(pmem_read & pmem_write), 256'(0));
      if (mem_resp) begin
        done = 1'b1;
        rd   = mem_rdata;
        if (!we) check("rdata", 256'(mem_rdata), 256'(arch_word(addr >> 2)));
      end
      @(posedge clk); #1;
    end
    if (!done) check("resp_timeout", 256'(0), 256'(1));
    was_hit = (cyc == 1);
    check("hit_vs_model", 256'(was_hit), 256'(exp_hit));
    check("latency", 256'(cyc), exp_hit ? 256'(1) : 256'(acc_pm_cycles + 2));
    exp_ops = exp_hit ? 0 : (exp_wb ? 2 : 1);
    check("op_count", 256'(ops_addr.size()), 256'(exp_ops));
    if (exp_wb) begin
      check("wb_addr", 256'({op_is_rd(0), op_addr(0)}), 256'({1'b0, victim << 5}));
      check("fetch_addr", 256'({op_is_rd(1), op_addr(1)}), 256'({1'b1, ln << 5}));
    end else if (!exp_hit) begin
      check("fetch_addr", 256'({op_is_rd(0), op_addr(0)}), 256'({1'b1, ln << 5}));
    end
    if (done) begin
      if (!exp_hit) res_dirty[set] = 1'b0;
      res_vld[set]  = 1'b1;
      res_line[set] = ln;
      if (we) begin
        res_dirty[set] = 1'b1;
        w = arch_word(addr >> 2);
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
        arch[addr >> 2] = w;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  rdv;
    logic [255:0] ln2;
    logic [23:0]  tags [4];
    int           cyc, tot_cyc, tot_pm;
    bit           h, seen;

    tags = '{24'h000000, 24'h000001, 24'h800001, 24'hFFFFFF};
    rst = 1'b1; mem_address = '0; mem_read = 0; mem_write = 0;
    mem_wdata = '0; mem_mbe = '0; pmem_rdata = '0; pmem_resp = 0;
    for (int s = 0; s < 8; s++) begin res_vld[s] = 0; res_dirty[s] = 0; res_line[s] = 0; end

    // Reset state.
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    check("rst_resp", 256'(mem_resp), 256'(0));
    check("rst_pmem_read", 256'(pmem_read), 256'(0));
    check("rst_pmem_write", 256'(pmem_write), 256'(0));
    check("rst_xfree", 256'($isunknown({mem_rdata, pmem_address, pmem_wdata})), 256'(0));
    @(posedge clk); #1;

    // Clean miss at 0x40 with a 3-cycle FETCH, word 2 = 0xDEADBEEF.
    ln2 = bk_line(2);
    ln2[95:64] = 32'hDEADBEEF;
    bk[2] = ln2;
    fixed_lat = 2;
    access(32'h40, 0, '0, '0, 0, rdv, cyc, h);
    check("dir_miss_latency", 256'(cyc), 256'(5));
    check("dir_fetch_addr", 256'(op_addr(0)), 256'(32'h40));
    access(32'h48, 0, '0, '0, 0, rdv, cyc, h);
    check("dir_read_48", 256'(rdv), 256'(32'hDEADBEEF));
    check("dir_read_48_hit", 256'(cyc), 256'(1));

    // Write hit on one byte lane, then read back merged word.
    access(32'h48, 1, 32'h0000AB00, 4'b0010, 0, rdv, cyc, h);
    check("dir_write_hit", 256'(cyc), 256'(1));
    access(32'h48, 0, '0, '0, 0, rdv, cyc, h);
    check("dir_merged", 256'(rdv), 256'(32'hDEADABEF));

    // Conflict miss evicts the dirty line before fetching.
    access(32'h140, 0, '0, '0, 0, rdv, cyc, h);
    check("dir_wb_addr", 256'(op_addr(0)), 256'(32'h40));
    check("dir_wb_word2", 256'(last_wb_data[95:64]), 256'(32'hDEADABEF));
    check("dir_fetch_140", 256'(op_addr(1)), 256'(32'h140));

    // Reset during FETCH.
    fixed_lat = 5;
    mem_address = 32'h248; mem_read = 1'b1; mem_write = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      serve_pmem();
      if (pmem_read) seen = 1;
      else begin @(posedge clk); #1; end
    end
    if (!seen) check("rst_fetch_timeout", 256'(0), 256'(1));
    rst = 1'b1;
    pmem_resp = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; mem_read = 1'b0;
    pm_busy = 0;
    for (int s = 0; s < 8; s++) begin res_vld[s] = 0; res_dirty[s] = 0; end
    arch.delete();
    @(negedge clk);
    check("rst_mid_pmem_read", 256'(pmem_read), 256'(0));
    check("rst_mid_pmem_write", 256'(pmem_write), 256'(0));
    check("rst_mid_resp", 256'(mem_resp), 256'(0));
    @(posedge clk); #1;
    fixed_lat = -1;
    access(32'h48, 0, '0, '0, 0, rdv, cyc, h);
    check("rst_reread_miss", 256'(h), 256'(0));
    check("rst_reread_data", 256'(rdv), 256'(32'hDEADABEF));

    // Warm all sets, then eight back-to-back hits.
    for (int s = 0; s < 8; s++) access(32'h1000 | 32'(s << 5), 0, '0, '0, 0, rdv, cyc, h);
    tot_cyc = 0; tot_pm = 0;
    for (int s = 0; s < 8; s++) begin
      access(32'h1004 | 32'(s << 5), 0, '0, '0, 0, rdv, cyc, h);
      tot_cyc += cyc;
      tot_pm  += acc_pm_cycles;
    end
    check("b2b_cycles", 256'(tot_cyc), 256'(8));
    check("b2b_pmem", 256'(tot_pm), 256'(0));

    // Random traffic over a small set of conflicting tags.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle();
      end else begin
        logic [31:0] a;
        bit          we;
        a  = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'b00};
        we = ($urandom_range(0, 2) == 0);
        access(a, we, $urandom, 4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)), rdv, cyc, h);
      end
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
